// File: rtl/deser_pkg.sv
// Shared constants and types for the serial-to-parallel deserializer.
// The build macro DESER_LSB_FIRST_EN selects LSB-first bit placement; MSB-first by default.
package deser_pkg;

  // Default word width: serial bits per parallel word.
  localparam int DATA_W_DEF = 16;

  // Bit counter width for a given word width; a 1-bit counter is the floor.
  function automatic int cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

  // Parallel word at the default width.
  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage : deser_pkg

// File: rtl/deser_bit_cnt.sv
// Accepted-bit counter for the deserializer.
// Counts enabled cycles 0..DATA_W-1, wraps to 0 on the last bit and flags that
// bit with a combinational done that is valid on the same edge.
module deser_bit_cnt
  import deser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0] cnt;

  // The bit being accepted this cycle is the last one of the word.
  assign done = en && (cnt == LAST);

  // Advance on each accepted bit; wrap after the last bit of a word.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule : deser_bit_cnt

// File: rtl/deserializer.sv
// Serial-to-parallel converter: gathers DATA_W qualified serial bits into a
// word and presents it with a one-cycle valid strobe, no backpressure.
// Build macro DESER_LSB_FIRST_EN: first accepted bit lands in bit 0 instead of
// bit DATA_W-1. Timing, counting and strobe are identical in both builds.
module deserializer
  import deser_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_next;
  logic              word_done;

  deser_bit_cnt #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_bit_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en      (data_val_i),
    .done    (word_done)
  );

  // Shift register contents once the current bit is included; on the last
  // bit this is the complete word, so the output register loads it directly.
  // NOTE: defaulting the output before any branch keeps this purely
  // combinational; a path that leaves it unassigned would infer a latch.
  always_comb begin
    shift_next = shift_q;
`ifdef DESER_LSB_FIRST_EN
    shift_next = {data_i, shift_q[DATA_W-1:1]};
`else
    shift_next = {shift_q[DATA_W-2:0], data_i};
`endif
  end

  // Accumulate accepted bits; idle cycles leave partial progress untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= '0;
    end else if (data_val_i) begin
      shift_q <= shift_next;
    end
  end

  // Publish the completed word and strobe for exactly one cycle; the word
  // register holds between completions so partial words never show.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      deser_data_o     <= '0;
      deser_data_val_o <= 1'b0;
    end else begin
      deser_data_val_o <= word_done;
      if (word_done) begin
        deser_data_o <= shift_next;
      end
    end
  end

endmodule : deserializer

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer (DATA_W = 16). Build with
// DESER_LSB_FIRST_EN defined to check the LSB-first variant.
module tb_deserializer;

  localparam int DW = 16;

`ifdef DESER_LSB_FIRST_EN
  localparam logic [DW-1:0] EXP_ALT = 16'h5555;
`else
  localparam logic [DW-1:0] EXP_ALT = 16'hAAAA;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          data_i;
  logic          data_val_i;
  logic [DW-1:0] deser_data_o;
  logic          deser_data_val_o;

  deserializer dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_val_o (deser_data_val_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of serial input, changing away from the sampling edge.
  task automatic drive(input logic b, input logic v);
    @(negedge clk_i);
    data_i     = b;
    data_val_i = v;
  endtask

  // Strobe monitor (outputs sampled on the falling edge).
  int            cyc      = 0;
  int            n_strobe = 0;
  int            strobe_cyc[$];
  logic [DW-1:0] strobe_word[$];

  // Scoreboard: reference words built only from accepted bits.
  logic          sb_en    = 1'b0;
  logic [DW-1:0] ref_word = '0;
  int            ref_k    = 0;
  int            accepted = 0;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk_i) begin
    if (sb_en && rst_n_i && data_val_i) begin
`ifdef DESER_LSB_FIRST_EN
      ref_word[ref_k] = data_i;
`else
      ref_word[DW-1-ref_k] = data_i;
`endif
      ref_k++;
      accepted++;
      if (ref_k == DW) begin
        exp_q.push_back(ref_word);
        ref_k = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    cyc++;
    if (deser_data_val_o) begin
      n_strobe++;
      strobe_cyc.push_back(cyc);
      strobe_word.push_back(deser_data_o);
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_strobe: got word 0x%0h with no reference word pending", deser_data_o);
        end else begin
          check("sb_word", 32'(deser_data_o), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  typedef struct {
    logic [DW-1:0] bits;     // serial order: bits[15] sent first
    int            gap_at;   // insert idle cycles before this bit index (-1: none)
    int            gap_len;
    logic [DW-1:0] exp_msb;
    logic [DW-1:0] exp_lsb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n0;
    int s0;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;

    vecs[0] = '{16'hFFFF, -1, 0, 16'hFFFF, 16'hFFFF};
    vecs[1] = '{16'h0000,  4, 4, 16'h0000, 16'h0000};
    vecs[2] = '{16'h8001, -1, 0, 16'h8001, 16'h8001};
    vecs[3] = '{16'h8000, -1, 0, 16'h8000, 16'h0001};
    vecs[4] = '{16'h1234,  2, 5, 16'h1234, 16'h2C48};
    vecs[5] = '{16'hC3A5,  7, 3, 16'hC3A5, 16'hA5C3};

    // Reset state.
    rst_n_i    = 1'b0;
    data_i     = 1'b0;
    data_val_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("reset_data", 32'(deser_data_o), 32'h0);
    check("reset_val", 32'(deser_data_val_o), 32'h0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Table-driven words, some with idle gaps (gap cycles carry data_i=1).
    for (int k = 0; k < 6; k++) begin
      b = vecs[k].bits;
`ifdef DESER_LSB_FIRST_EN
      exp = vecs[k].exp_lsb;
`else
      exp = vecs[k].exp_msb;
`endif
      n0 = n_strobe;
      for (int i = 0; i < DW; i++) begin
        if (i == vecs[k].gap_at) begin
          repeat (vecs[k].gap_len) drive(1'b1, 1'b0);
        end
        drive(b[DW-1-i], 1'b1);
      end
      check($sformatf("vec%0d_no_early_strobe", k), 32'(n_strobe), 32'(n0));
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_strobe", k), 32'(deser_data_val_o), 32'h1);
      check($sformatf("vec%0d_word", k), 32'(deser_data_o), 32'(exp));
      @(negedge clk_i);
      data_val_i = 1'b0;
      @(posedge clk_i); #1;
      check($sformatf("vec%0d_strobe_single", k), 32'(deser_data_val_o), 32'h0);
    end

    // Back-to-back: 48 continuous alternating bits starting with 1.
    s0 = strobe_cyc.size();
    for (int i = 0; i < 48; i++) begin
      drive((i % 2) == 0, 1'b1);
      if (i == 24) check("b2b_hold", 32'(deser_data_o), 32'(EXP_ALT));
    end
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    check("b2b_strobe_count", 32'(strobe_cyc.size() - s0), 32'd3);
    for (int j = 1; j < 3; j++) begin
      if (strobe_cyc.size() > s0 + j)
        check($sformatf("b2b_spacing%0d", j), 32'(strobe_cyc[s0+j] - strobe_cyc[s0+j-1]), 32'd16);
    end
    for (int j = 0; j < 3; j++) begin
      if (strobe_word.size() > s0 + j)
        check($sformatf("b2b_word%0d", j), 32'(strobe_word[s0+j]), 32'(EXP_ALT));
    end

    // Asynchronous reset mid-word after 7 accepted bits.
    repeat (7) drive(1'b1, 1'b1);
    @(posedge clk_i); #2;
    data_val_i = 1'b0;
    rst_n_i    = 1'b0;
    #1;
    check("midrst_data", 32'(deser_data_o), 32'h0);
    check("midrst_val", 32'(deser_data_val_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    n0 = n_strobe;
    repeat (15) drive(1'b1, 1'b1);
    @(posedge clk_i); #1;
    check("midrst_no_strobe_at_15", 32'(deser_data_val_o), 32'h0);
    check("midrst_no_early_strobe", 32'(n_strobe), 32'(n0));
    drive(1'b1, 1'b1);
    @(posedge clk_i); #1;
    check("midrst_strobe", 32'(deser_data_val_o), 32'h1);
    check("midrst_word", 32'(deser_data_o), 32'hFFFF);
    @(negedge clk_i);
    data_val_i = 1'b0;

    // Random valid duty with scoreboard.
    @(negedge clk_i);
    ref_k    = 0;
    accepted = 0;
    n0       = n_strobe;
    sb_en    = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    drive(1'b0, 1'b0);
    repeat (2) @(negedge clk_i);
    sb_en = 1'b0;
    check("rand_strobe_count", 32'(n_strobe - n0), 32'(accepted / DW));
    check("rand_pending_words", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_deserializer

// File: doc/deserializer.md
Name: deserializer

Overview:
Serial-to-parallel converter that collects DATA_W qualified serial bits into one parallel word. It emits the word with a single-cycle valid strobe when the word is complete. It sits between a 1-bit serial source with a per-bit valid and any parallel word consumer. There is no backpressure: the consumer must take the word on the strobe cycle.

Parameters:
DATA_W, 16, width of the output word and number of serial bits per word (legal range 2 and up).
CNT_W, $clog2(DATA_W), width of the internal bit counter (derived; do not override).

Ports:
clk_i  input  1  single clock; all logic is on the rising edge.
rst_n_i  input  1  asynchronous active-low reset.
data_i  input  1  serial data bit; sampled only when data_val_i=1.
data_val_i  input  1  qualifies data_i on this clock edge.
deser_data_o  output  DATA_W  assembled parallel word.
deser_data_val_o  output  1  one-cycle strobe; deser_data_o is valid while it is high.

Behaviour:
- Interface: one clock, asynchronous active-low reset, as already decided.
- Reset (rst_n_i=0, asynchronous): bit counter=0, shift register=0, deser_data_o=0, deser_data_val_o=0. Release is synchronous to clk_i.
- Bit acceptance:
  - A bit is accepted on each rising edge with data_val_i=1.
  - Cycles with data_val_i=0 are ignored entirely: no shift, no count change, data_i is don't-care.
  - Gaps of any length between accepted bits are allowed; partial progress is kept across gaps.
- Bit order (default, MSB first): the first accepted bit of a word lands in deser_data_o[DATA_W-1]; the last lands in bit 0.
- Counter:
  - Counts accepted bits 0..DATA_W-1.
  - On the DATA_W-th accepted bit, the counter wraps to 0 and the word completes.
- Output timing:
  - On the edge accepting the DATA_W-th bit, deser_data_o is registered with the full word, including that bit.
  - deser_data_val_o goes high for exactly one cycle, the cycle after that edge.
  - Latency is 1 clock from the last bit's sampling edge to the strobe.
- Back-to-back words: if data_val_i stays high, the next word's first bit is accepted on the very next edge. One strobe then appears every DATA_W cycles with no dead cycle.
- Hold: deser_data_o keeps the last completed word until the next word completes. Partial accumulation never disturbs deser_data_o; a separate shift register is used.
- deser_data_val_o is never high for two consecutive cycles when DATA_W >= 2.
- Reset mid-word: the partial word is discarded and the counter returns to 0. The next accepted bit is the first bit of a new word.
- No error or overflow conditions exist.

Optional Feature:
Macro DESER_LSB_FIRST_EN.
- Defined: the first accepted bit lands in deser_data_o[0] and the last in deser_data_o[DATA_W-1] (shift toward LSB).
- Undefined: MSB-first as described above.
- Timing, counter and strobe behaviour are identical in both builds.

Decomposition:
- Package deser_pkg:
  - DATA_W default constant.
  - CNT_W derivation function/constant.
  - Word typedef logic [DATA_W-1:0].
- No sub-module is needed; a shift register, a counter and an output register fit in one module.
- Optionally factor the counter as deser_bit_cnt (increment on enable, wrap at DATA_W-1, done pulse).

Test Plan:
- Reset, then data_val_i=1 and data_i=1 for 16 consecutive cycles -> one strobe, 1 cycle after the 16th edge, with deser_data_o=16'hFFFF; the strobe lasts exactly 1 cycle.
- After that word, data_i=0 valid for 4 cycles, then data_val_i=0 with data_i=1 for 4 cycles, then data_i=0 valid for 12 cycles -> no strobe during the gap; strobe after the 12th bit with deser_data_o=16'h0000; the gap bits are ignored.
- Serial pattern 1,0,0,...,0,1 (16 bits, valid each cycle) -> 16'h8001 by default; 16'h8001 also with DESER_LSB_FIRST_EN. Pattern 1 then 15 zeros -> 16'h8000 by default, 16'h0001 with the macro.
- Continuous valid for 48 cycles with an alternating pattern starting at 1 -> 3 strobes spaced exactly 16 cycles apart, each with 16'hAAAA (default). deser_data_o holds between strobes.
- Reset asserted asynchronously (mid-cycle) after 7 valid bits, then 16 valid ones -> outputs 0 immediately on assertion; the next strobe occurs only after all 16 new bits, with 16'hFFFF.
- Random data_val_i duty (~50%) over 1000 cycles with a scoreboard -> every strobe matches the reference word built from accepted bits only; strobe count = floor(accepted/16).
